// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the 1-entry request buffer layout.
package rv32i_types;

  localparam int unsigned BUF_ADDR_W = 32;
  localparam int unsigned BUF_DATA_W = 32;
  localparam int unsigned BUF_MASK_W = BUF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [BUF_ADDR_W-1:0] addr;
    logic [BUF_MASK_W-1:0] rmask;
    logic [BUF_MASK_W-1:0] wmask;
    logic [BUF_DATA_W-1:0] wdata;
  } mem_req_buf_t;

endpackage

// File: rtl/mem_port_arbiter_req_buf.sv
// One-entry request holding register; a capture wins over a same-cycle clear or cancel.
// Latency 1 (captured entry visible the cycle after the pulse); no backpressure, caller guarantees one outstanding.
module req_buf
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_vld,
  input  mem_req_buf_t cap_dat,
  input  logic         clr,
  input  logic         cancel,
  output mem_req_buf_t ent_dat
);

  mem_req_buf_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (clr || cancel) begin
      ent_d.valid = 1'b0;
    end
    if (cap_vld) begin
      ent_d       = cap_dat;
      ent_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent_dat = ent_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between imem and dmem (dmem priority); grant issues the cycle after capture, resp forwarded same cycle.
// No backpressure: each side holds one request at a time. MEM_ARB_STARVE_GUARD_EN forces imem through after STARVE_LIMIT dmem grants.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W/8-1:0] imem_rmask,
  input  logic                imem_cancel,
  output logic                imem_resp,
  output logic [DATA_W-1:0]   imem_rdata,
  input  logic                dmem_req,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W/8-1:0] dmem_rmask,
  input  logic [DATA_W/8-1:0] dmem_wmask,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic                dmem_resp,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [MASK_W-1:0]   mem_rmask_q, mem_rmask_d;
  logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                drop_i_q, drop_i_d;
  logic                grant_i, grant_d;
  logic                i_avail, force_i;
  mem_req_buf_t        icap, dcap, ient, dent, sel;

  always_comb begin
    icap       = '0;
    icap.addr  = BUF_ADDR_W'(imem_addr);
    icap.rmask = BUF_MASK_W'(imem_rmask);
    dcap       = '0;
    dcap.addr  = BUF_ADDR_W'(dmem_addr);
    dcap.rmask = BUF_MASK_W'(dmem_rmask);
    dcap.wmask = BUF_MASK_W'(dmem_wmask);
    dcap.wdata = BUF_DATA_W'(dmem_wdata);
  end

  req_buf u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .cap_vld (imem_req),
    .cap_dat (icap),
    .clr     (grant_i),
    .cancel  (imem_cancel),
    .ent_dat (ient)
  );

  req_buf u_dbuf (
    .clk     (clk),
    .rst     (rst),
    .cap_vld (dmem_req),
    .cap_dat (dcap),
    .clr     (grant_d),
    .cancel  (1'b0),
    .ent_dat (dent)
  );

  // A fetch being flushed this very cycle must not be granted.
  assign i_avail = ient.valid && !imem_cancel;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_i = i_avail && (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d && ient.valid && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_i             = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rmask_d = mem_rmask_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    drop_i_d    = drop_i_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    sel         = dent;
    case (state_q)
      IDLE: begin
        if (dent.valid && !force_i) begin
          grant_d = 1'b1;
        end else if (i_avail) begin
          grant_i = 1'b1;
        end
        if (grant_d || grant_i) begin
          sel         = grant_d ? dent : ient;
          state_d     = grant_d ? BUSY_D : BUSY_I;
          mem_req_d   = 1'b1;
          mem_addr_d  = sel.addr[ADDR_W-1:0];
          mem_rmask_d = sel.rmask[MASK_W-1:0];
          mem_wmask_d = sel.wmask[MASK_W-1:0];
          mem_wdata_d = sel.wdata[DATA_W-1:0];
        end
      end
      BUSY_I: begin
        if (imem_cancel) begin
          drop_i_d = 1'b1;
        end
        if (mem_resp) begin
          state_d  = IDLE;
          drop_i_d = 1'b0;
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      drop_i_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_rmask_q <= mem_rmask_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      drop_i_q    <= drop_i_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rmask = mem_rmask_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;

  // Stores never return data, whatever the memory drives on mem_rdata.
  assign imem_resp  = (state_q == BUSY_I) && mem_resp && !drop_i_q && !imem_cancel;
  assign dmem_resp  = (state_q == BUSY_D) && mem_resp;
  assign imem_rdata = imem_resp ? mem_rdata : '0;
  assign dmem_rdata = (dmem_resp && (mem_wmask_q == '0)) ? mem_rdata : '0;

  a_imem_single: assert property (@(posedge clk) disable iff (rst)
    imem_req |-> imem_cancel || (!ient.valid && ((state_q != BUSY_I) || mem_resp)));
  a_dmem_single: assert property (@(posedge clk) disable iff (rst)
    dmem_req |-> !dent.valid && ((state_q != BUSY_D) || mem_resp));

endmodule
